// File: rtl/fifo_rd_packer_if.sv
// Handshake bundle between the byte FIFO read port, the packer and the word sink.
// master = packer side, slave = FIFO/sink/flush-requester side.
interface fifo_rd_packer_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [W-1:0]     fifo_rd_data;
  logic             flush;
  logic [W*N-1:0]   data;
  logic             valid;
  logic             ready;
  logic [3:0]       byte_cnt;
  logic             last;
  logic             busy;

  modport master (
    input  fifo_empty, fifo_rd_data, flush, ready,
    output fifo_rd_en, data, valid, byte_cnt, last, busy
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush, ready,
    input  fifo_rd_en, data, valid, byte_cnt, last, busy
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains bytes from the FIFO read port and packs N of them (first byte at LSB)
// into words on a valid/ready stream; a flush emits the partial word tagged last.
module fifo_rd_packer #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  fifo_rd_packer_if.master  bus
);

  logic [N-1:0][W-1:0] acc_reg;
  logic [N-1:0][W-1:0] acc_next;
  logic [3:0]          cnt_reg;
  logic                inflight_reg;
  logic                flush_pending_reg;
  logic [W*N-1:0]      data_reg;
  logic                valid_reg;
  logic [3:0]          out_cnt_reg;
  logic                last_reg;

  logic                out_free;
  logic                full;
  logic                xfer;
  logic [3:0]          eff_cnt;
  logic [4:0]          committed;
  logic                rd_en;

  always_comb begin
    out_free  = !valid_reg || bus.ready;
    full      = (cnt_reg == 4'(N));
    xfer      = out_free && (full || (flush_pending_reg && !inflight_reg && cnt_reg != 4'd0));
    eff_cnt   = xfer ? 4'd0 : cnt_reg;
    // Bytes already owned by the accumulator plus the one still on its way.
    committed = {1'b0, eff_cnt} + {4'd0, inflight_reg};
    rd_en     = !rd_rst && !bus.fifo_empty && !flush_pending_reg && (committed < 5'(N));
  end

  // Emptied slots are cleared on transfer so a partial word carries zero upper bytes.
  for (genvar gi = 0; gi < N; gi++) begin : g_acc
    assign acc_next[gi] = (inflight_reg && cnt_reg == 4'(gi)) ? bus.fifo_rd_data :
                          xfer                                 ? '0               :
                                                                 acc_reg[gi];
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      acc_reg           <= '0;
      cnt_reg           <= 4'd0;
      inflight_reg      <= 1'b0;
      flush_pending_reg <= 1'b0;
      data_reg          <= '0;
      valid_reg         <= 1'b0;
      out_cnt_reg       <= 4'd0;
      last_reg          <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      acc_reg      <= acc_next;

      if (xfer) begin
        cnt_reg <= 4'd0;
      end else if (inflight_reg) begin
        cnt_reg <= cnt_reg + 4'd1;
      end

      // A flush with nothing held or in flight retires without emitting a word.
      if (flush_pending_reg) begin
        if (xfer || (!inflight_reg && cnt_reg == 4'd0)) begin
          flush_pending_reg <= 1'b0;
        end
      end else if (bus.flush) begin
        flush_pending_reg <= 1'b1;
      end

      if (xfer) begin
        data_reg    <= acc_reg;
        valid_reg   <= 1'b1;
        out_cnt_reg <= cnt_reg;
        last_reg    <= flush_pending_reg;
      end else if (bus.ready) begin
        valid_reg   <= 1'b0;
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.data       = data_reg;
  assign bus.valid      = valid_reg;
  assign bus.byte_cnt   = out_cnt_reg;
  assign bus.last       = last_reg;
  assign bus.busy       = flush_pending_reg || inflight_reg || (cnt_reg != 4'd0);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: behavioural byte FIFO on the read side and
// a scoreboard of expected words popped whenever a word is accepted.
module tb_fifo_rd_packer;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W*N-1:0] data;
    logic [3:0]     cnt;
    logic           last;
  } word_t;

  logic rd_clk;
  logic rd_rst;

  fifo_rd_packer_if #(.N(N), .W(W)) bus ();

  fifo_rd_packer #(.N(N), .W(W)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .bus    (bus.master)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // Byte FIFO: data appears the cycle after an accepted read.
  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_rd_data <= mem[rd_ptr % 64];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  word_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] en_hist;
  logic [31:0] vld_hist;

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
  endtask

  task automatic clear_hist();
    cyc      = 0;
    en_hist  = '0;
    vld_hist = '0;
  endtask

  // One clock cycle: sample outputs mid-cycle, score an accepted word, advance.
  task automatic step();
    word_t e;
    #1;
    if (cyc < 32) begin
      en_hist[cyc]  = bus.fifo_rd_en;
      vld_hist[cyc] = bus.valid;
    end
    if (bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word_valid", 64'(bus.valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        $display("word cyc=%0d data=0x%08h cnt=%0d last=%0d", cyc, bus.data, bus.byte_cnt, bus.last);
        chk("word_data", 64'(bus.data), 64'(e.data));
        chk("word_cnt",  64'(bus.byte_cnt), 64'(e.cnt));
        chk("word_last", 64'(bus.last), 64'(e.last));
      end
    end
    cyc++;
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    rd_rst    = 1'b1;
    bus.ready = 1'b0;
    bus.flush = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));

    // Reset state with a non-empty FIFO
    #13;
    chk("rst_rd_en",    64'(bus.fifo_rd_en), 64'd0);
    chk("rst_valid",    64'(bus.valid), 64'd0);
    chk("rst_data",     64'(bus.data), 64'd0);
    chk("rst_byte_cnt", 64'(bus.byte_cnt), 64'd0);
    chk("rst_last",     64'(bus.last), 64'd0);
    chk("rst_busy",     64'(bus.busy), 64'd0);
    @(posedge rd_clk);
    #1;
    rd_rst    = 1'b0;
    bus.ready = 1'b1;

    // Full-word streaming
    exp_q.push_back('{32'h04030201, 4'd4, 1'b0});
    exp_q.push_back('{32'h08070605, 4'd4, 1'b0});
    clear_hist();
    for (int i = 0; i < 14; i++) step();
    chk("stream_rd_en_cycles", 64'(en_hist),  64'h1EF);
    chk("stream_valid_cycles", 64'(vld_hist), 64'h840);
    chk("stream_idle_busy",    64'(bus.busy), 64'd0);

    // Backpressure until cycle 20
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    exp_q.push_back('{32'h04030201, 4'd4, 1'b0});
    exp_q.push_back('{32'h08070605, 4'd4, 1'b0});
    clear_hist();
    for (int i = 0; i < 24; i++) begin
      bus.ready = (i >= 20);
      if (i == 12 || i == 19) begin
        #1;
        chk("bp_data_held", 64'(bus.data), 64'h04030201);
        chk("bp_busy",      64'(bus.busy), 64'd1);
      end
      step();
    end
    chk("bp_rd_en_cycles", 64'(en_hist),  64'h1EF);
    chk("bp_valid_cycles", 64'(vld_hist), 64'h3FFFC0);

    // Partial flush of three bytes
    push_byte(8'hAA);
    push_byte(8'hBB);
    push_byte(8'hCC);
    exp_q.push_back('{32'h00CCBBAA, 4'd3, 1'b1});
    clear_hist();
    for (int i = 0; i < 6; i++) step();
    chk("partial_busy_held", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("partial_busy_done", 64'(bus.busy), 64'd0);

    // Flush coinciding with the second read
    for (int i = 0; i < 4; i++) push_byte(8'(8'h21 + i));
    exp_q.push_back('{32'h00002221, 4'd2, 1'b1});
    exp_q.push_back('{32'h00002423, 4'd2, 1'b1});
    clear_hist();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("inflight_rd_en_cycles", 64'(en_hist), 64'h33);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("inflight_busy_done", 64'(bus.busy), 64'd0);

    // Flush with nothing held
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("empty_flush_busy_set",   64'(bus.busy), 64'd1);
    step();
    chk("empty_flush_busy_clear", 64'(bus.busy), 64'd0);
    chk("empty_flush_no_valid",   64'(bus.valid), 64'd0);

    // Asynchronous reset with two bytes held
    push_byte(8'h51);
    push_byte(8'h52);
    for (int i = 0; i < 5; i++) step();
    chk("midrst_busy_before", 64'(bus.busy), 64'd1);
    #2;
    rd_rst = 1'b1;
    #1;
    chk("midrst_busy",  64'(bus.busy), 64'd0);
    chk("midrst_valid", 64'(bus.valid), 64'd0);
    @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h11 + i));
    exp_q.push_back('{32'h14131211, 4'd4, 1'b0});
    for (int i = 0; i < 10; i++) step();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
